holy_trace_buffer: RTL and testbench

Parametrised execution-trace capture block for Holy Core SoCs.
- Monitors the core's debug outputs (pc, pc_next, instruction, i/d cache stalls) and records retired instructions into an on-chip FIFO.
- Firmware or a debugger drains the FIFO through an AXI-Lite slave register port.
- Sits beside the core top and slaves off the system interconnect's AXI-Lite segment.

---
 rtl/holy_trace_pkg.sv | 35 +++
 rtl/holy_trace_fifo.sv | 76 +++++++
 rtl/holy_trace_buffer.sv | 187 ++++++++++++++++++
 tb/tb_holy_trace_buffer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/holy_trace_pkg.sv
// Shared constants and types for the Holy Core execution-trace buffer:
// register map, bit positions, AXI responses, trace entry layout, FSM states.
package holy_trace_pkg;

  localparam int TRACE_XLEN = 32;

  localparam logic [7:0] CTRL_OFF       = 8'h00;
  localparam logic [7:0] STATUS_OFF     = 8'h04;
  localparam logic [7:0] HEAD_PC_OFF    = 8'h08;
  localparam logic [7:0] HEAD_INSTR_OFF = 8'h0C;
  localparam logic [7:0] HEAD_FLAGS_OFF = 8'h10;
  localparam logic [7:0] THRESH_OFF     = 8'h14;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_WRAP_BIT   = 1;
  localparam int CTRL_BRONLY_BIT = 2;
  localparam int CTRL_CLR_BIT    = 3;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] instr;
    logic                  disc;
  } trace_entry_t;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

endpackage

// File: rtl/holy_trace_fifo.sv
// Synchronous trace FIFO with clear, stop/wrap overflow handling and a
// one-cycle overflow pulse for the sticky status bit kept by the parent.
module holy_trace_fifo #(
  parameter int DATA_W = 65,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic                     wrap_mode,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_wr, adv_rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop on a non-empty FIFO always frees the slot the push needs.
  always_comb begin
    do_wr     = 1'b0;
    adv_rd    = 1'b0;
    ovf_pulse = 1'b0;
    if (!clr) begin
      if (push && pop && !empty) begin
        do_wr  = 1'b1;
        adv_rd = 1'b1;
      end else if (push) begin
        if (!full) begin
          do_wr = 1'b1;
        end else begin
          ovf_pulse = 1'b1;
          do_wr     = wrap_mode;
          adv_rd    = wrap_mode;
        end
      end else if (pop && !empty) begin
        adv_rd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !adv_rd)      count <= count + 1'b1;
      else if (!do_wr && adv_rd) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/holy_trace_buffer.sv
// Execution-trace capture for Holy Core: filters retired instructions into a
// FIFO drained through an AXI-Lite register slave, with a count-threshold IRQ.
module holy_trace_buffer
  import holy_trace_pkg::*;
#(
  parameter int XLEN   = TRACE_XLEN,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   pc_next,
  input  logic [XLEN-1:0]   instruction,
  input  logic              i_cache_stall,
  input  logic              d_cache_stall,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [XLEN-1:0]   s_axi_wdata,
  input  logic [XLEN/8-1:0] s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [XLEN-1:0]   s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              trace_irq
);

  localparam int AW = $clog2(DEPTH);

  logic              live;
  logic [2:0]        ctrl;
  logic              ovf;
  logic [15:0]       thresh;
  logic              retire, disc, capture, clr, pop;
  trace_entry_t      new_entry, head;
  logic [AW:0]       count;
  logic              full, empty, ovf_pulse;

  // pc + 4 wraps at XLEN bits, so 0xFFFFFFFC -> 0 counts as sequential.
  assign retire    = !i_cache_stall && !d_cache_stall;
  assign disc      = (pc_next != pc + XLEN'(4));
  assign capture   = ctrl[CTRL_EN_BIT] && retire && (!ctrl[CTRL_BRONLY_BIT] || disc);
  assign new_entry = '{pc: pc, instr: instruction, disc: disc};

  holy_trace_fifo #(.DATA_W($bits(trace_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk, .rst, .push(capture), .pop(pop), .clr(clr),
    .wrap_mode(ctrl[CTRL_WRAP_BIT]), .din(new_entry), .head(head),
    .count(count), .full(full), .empty(empty), .ovf_pulse(ovf_pulse)
  );

  w_state_t          w_state, w_next;
  logic              aw_held, w_held, aw_hs, w_hs, do_write, wr_err;
  logic [ADDR_W-1:0] aw_addr, aw_off;
  logic [XLEN-1:0]   w_data;
  logic [XLEN/8-1:0] w_strb;

  // Ready stays low during and just after reset so every output reads 0 then.
  assign s_axi_awready = live && (w_state == W_IDLE) && !aw_held;
  assign s_axi_wready  = live && (w_state == W_IDLE) && !w_held;
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign aw_off = {aw_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_next   = w_state;
    do_write = 1'b0;
    wr_err   = 1'b1;
    clr      = 1'b0;
    if (aw_off == ADDR_W'(CTRL_OFF) || aw_off == ADDR_W'(THRESH_OFF)) wr_err = 1'b0;
    case (w_state)
      W_IDLE: if (aw_held && w_held) begin
        do_write = 1'b1;
        w_next   = W_RESP;
        clr      = (aw_off == ADDR_W'(CTRL_OFF)) && w_strb[0] && w_data[CTRL_CLR_BIT];
      end
      W_RESP: if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr <= s_axi_awaddr;
    if (w_hs) begin
      w_data <= s_axi_wdata;
      w_strb <= s_axi_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live        <= 1'b0;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      ctrl        <= '0;
      thresh      <= 16'(DEPTH / 2);
      s_axi_bresp <= RESP_OKAY;
      ovf         <= 1'b0;
      trace_irq   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (aw_hs)         aw_held <= 1'b1;
      else if (do_write) aw_held <= 1'b0;
      if (w_hs)          w_held  <= 1'b1;
      else if (do_write) w_held  <= 1'b0;
      if (do_write) begin
        s_axi_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (aw_off == ADDR_W'(CTRL_OFF) && w_strb[0]) ctrl <= w_data[2:0];
        if (aw_off == ADDR_W'(THRESH_OFF)) begin
          if (w_strb[0]) thresh[7:0]  <= w_data[7:0];
          if (w_strb[1]) thresh[15:8] <= w_data[15:8];
        end
      end
      if (clr)            ovf <= 1'b0;
      else if (ovf_pulse) ovf <= 1'b1;
      trace_irq <= (thresh != 16'd0) && (16'(count) >= thresh);
    end
  end

  r_state_t          r_state, r_next;
  logic              ar_hs, rd_err;
  logic [ADDR_W-1:0] ar_off;
  logic [XLEN-1:0]   rd_val;

  assign s_axi_arready = live && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_RESP);
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign ar_off = {s_axi_araddr[ADDR_W-1:2], 2'b00};

  // An empty HEAD_INSTR read must not pop, so pop is gated on !empty here.
  always_comb begin
    r_next = r_state;
    rd_val = '0;
    rd_err = 1'b0;
    pop    = 1'b0;
    case (ar_off)
      ADDR_W'(CTRL_OFF):       rd_val = XLEN'(ctrl);
      ADDR_W'(STATUS_OFF):     rd_val = XLEN'({ovf, full, empty, 16'(count)});
      ADDR_W'(HEAD_PC_OFF):    rd_val = empty ? '0 : head.pc;
      ADDR_W'(HEAD_INSTR_OFF): begin
        rd_err = empty;
        rd_val = empty ? '0 : head.instr;
        pop    = ar_hs && !empty;
      end
      ADDR_W'(HEAD_FLAGS_OFF): rd_val = XLEN'(head.disc && !empty);
      ADDR_W'(THRESH_OFF):     rd_val = XLEN'(thresh);
      default:                 rd_err = 1'b1;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        s_axi_rdata <= rd_val;
        s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{aw_addr[1:0], s_axi_araddr[1:0], w_data[XLEN-1:16], w_strb[XLEN/8-1:2]};

endmodule

// File: tb/tb_holy_trace_buffer.sv
// Directed and randomized bench for holy_trace_buffer (DEPTH=4) against a
// queue-based model of the trace FIFO and register behaviour.
module tb_holy_trace_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, pc_next, instruction;
  logic        i_cache_stall, d_cache_stall;
  logic [4:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready, trace_irq;

  holy_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next), .instruction(instruction),
    .i_cache_stall(i_cache_stall), .d_cache_stall(d_cache_stall),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .trace_irq(trace_irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        disc;
  } ent_t;

  ent_t        q[$];
  bit          m_ovf, m_en, m_wrap, m_bronly;
  logic [15:0] m_thresh;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL timeout_%s: observed no handshake, expected handshake", tag);
  endtask

  task automatic model_retire(input logic [31:0] p, pn, ins, input bit stalled);
    ent_t e;
    e.pc = p; e.instr = ins; e.disc = (pn != p + 32'd4);
    if (m_en && !stalled && (!m_bronly || e.disc)) begin
      if (q.size() == DEPTH) begin
        m_ovf = 1'b1;
        if (m_wrap) begin
          void'(q.pop_front());
          q.push_back(e);
        end
      end else begin
        q.push_back(e);
      end
    end
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a == 5'h00 && s[0]) begin
      m_en = d[0]; m_wrap = d[1]; m_bronly = d[2];
      if (d[3]) begin
        q.delete();
        m_ovf = 1'b0;
      end
    end
    if (a == 5'h14) begin
      if (s[0]) m_thresh[7:0]  = d[7:0];
      if (s[1]) m_thresh[15:8] = d[15:8];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    s_axi_awaddr = 0; s_axi_araddr = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    i_cache_stall = 1; d_cache_stall = 0; pc = 0; pc_next = 0; instruction = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    q.delete(); m_ovf = 0; m_en = 0; m_wrap = 0; m_bronly = 0; m_thresh = 16'(DEPTH / 2);
  endtask

  task automatic retire(input logic [31:0] p, pn, ins, input logic is, ds);
    pc = p; pc_next = pn; instruction = ins; i_cache_stall = is; d_cache_stall = ds;
    @(posedge clk); #1;
    i_cache_stall = 1; d_cache_stall = 0;
    model_retire(p, pn, ins, is || ds);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    logic aw_go, w_go;
    resp = 2'bxx;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s; s_axi_awvalid = 1; s_axi_wvalid = 1;
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 50) begin
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      n++;
      if (aw_go) s_axi_awvalid = 0;
      if (w_go)  s_axi_wvalid = 0;
    end
    if (s_axi_awvalid || s_axi_wvalid) begin
      timeout("aw_w");
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      return;
    end
    s_axi_bready = 1;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_axi_bvalid) begin
      timeout("b");
      s_axi_bready = 0;
      return;
    end
    resp = s_axi_bresp;
    @(posedge clk); #1;
    s_axi_bready = 0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    d = 'x; r = 2'bxx;
    s_axi_araddr = a; s_axi_arvalid = 1;
    n = 0;
    while (!s_axi_arready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_axi_arready) begin
      timeout("ar");
      s_axi_arvalid = 0;
      return;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 0; s_axi_rready = 1;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_axi_rvalid) begin
      timeout("r");
      s_axi_rready = 0;
      return;
    end
    d = s_axi_rdata; r = s_axi_rresp;
    @(posedge clk); #1;
    s_axi_rready = 0;
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] resp;
    axi_write(a, d, s, resp);
    check($sformatf("bresp_%h", a), {30'b0, resp}, (a == 5'h00 || a == 5'h14) ? 32'd0 : 32'd2);
    model_write(a, d, s);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d, exp;
    logic [1:0]  r;
    axi_read(5'h04, d, r);
    exp = {13'b0, m_ovf, q.size() == DEPTH, q.size() == 0, 16'(q.size())};
    check({tag, "_status"}, d, exp);
  endtask

  task automatic check_head(input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    if (q.size() > 0) begin
      axi_read(5'h08, d, r);
      check({tag, "_head_pc"}, d, q[0].pc);
      axi_read(5'h10, d, r);
      check({tag, "_head_flags"}, d, {31'b0, q[0].disc});
    end
    axi_read(5'h0C, d, r);
    if (q.size() > 0) begin
      check({tag, "_head_instr"}, d, q[0].instr);
      check({tag, "_instr_resp"}, {30'b0, r}, 32'd0);
      void'(q.pop_front());
    end else begin
      check({tag, "_empty_instr"}, d, 32'd0);
      check({tag, "_empty_resp"}, {30'b0, r}, 32'd2);
    end
  endtask

  task automatic idle_irq_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_irq"}, {31'b0, trace_irq},
          {31'b0, (m_thresh != 16'd0) && (q.size() >= int'(m_thresh))});
  endtask

  logic [31:0] rd, cur_pc, nxt_pc;
  logic [1:0]  rr;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    i_cache_stall = 1; d_cache_stall = 0;
    #12;
    check("rst_awready", {31'b0, s_axi_awready}, 0);
    check("rst_arready", {31'b0, s_axi_arready}, 0);
    check("rst_bvalid", {31'b0, s_axi_bvalid}, 0);
    check("rst_rvalid", {31'b0, s_axi_rvalid}, 0);
    check("rst_irq", {31'b0, trace_irq}, 0);
    check("rst_rdata", s_axi_rdata, 0);
    do_reset();
    check_status("reset");
    axi_read(5'h14, rd, rr);
    check("reset_thresh", rd, 32'd2);
    axi_read(5'h00, rd, rr);
    check("reset_ctrl", rd, 32'd0);

    // Basic capture
    reg_write(5'h00, 32'h1, 4'hF);
    retire(32'h100, 32'h104, 32'h13, 0, 0);
    retire(32'h104, 32'h108, 32'h13, 0, 0);
    retire(32'h108, 32'h10C, 32'h13, 0, 0);
    axi_read(5'h04, rd, rr);
    check("basic_count3", rd, 32'h3);
    check_head("basic");
    check_status("basic_after_pop");

    // Stall gating and branch-only
    do_reset();
    reg_write(5'h00, 32'h5, 4'hF);
    retire(32'h200, 32'h204, 32'hA1, 0, 0);
    repeat (3) retire(32'h204, 32'h400, 32'hA2, 0, 1);
    retire(32'h204, 32'h400, 32'hA2, 0, 0);
    retire(32'hFFFF_FFFC, 32'h0, 32'hA3, 0, 0);
    check_status("bronly");
    check_head("bronly");

    // Full, stop mode then wrap mode
    do_reset();
    reg_write(5'h00, 32'h1, 4'hF);
    for (int i = 0; i < 6; i++) retire(32'(i * 4), 32'(i * 4 + 4), 32'(32'h500 + i), 0, 0);
    axi_read(5'h04, rd, rr);
    check("stop_status", rd, 32'h0006_0004);
    check_head("stop");
    do_reset();
    reg_write(5'h00, 32'h3, 4'hF);
    for (int i = 0; i < 6; i++) retire(32'(i * 4), 32'(i * 4 + 4), 32'(32'h600 + i), 0, 0);
    check_status("wrap");
    axi_read(5'h08, rd, rr);
    check("wrap_head_pc", rd, 32'h8);
    for (int i = 0; i < 5; i++) check_head("wrap_drain");

    // Empty pop, unmapped and read-only accesses, byte lanes
    do_reset();
    axi_read(5'h0C, rd, rr);
    check("empty_pop_data", rd, 32'd0);
    check("empty_pop_resp", {30'b0, rr}, 32'd2);
    check_status("empty_pop");
    axi_read(5'h1C, rd, rr);
    check("unmapped_rresp", {30'b0, rr}, 32'd2);
    reg_write(5'h04, 32'hFFFF_FFFF, 4'hF);
    reg_write(5'h18, 32'h1, 4'hF);
    reg_write(5'h14, 32'h0000_0503, 4'h2);
    axi_read(5'h14, rd, rr);
    check("thresh_lane1", rd, 32'h0000_0502);

    // AXI ordering: W two cycles ahead of AW, B back-pressured for 5 cycles
    do_reset();
    reg_write(5'h00, 32'h1, 4'hF);
    s_axi_wdata = 32'd3; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    @(posedge clk); #1;
    s_axi_wvalid = 0;
    check("w_first_wready", {31'b0, s_axi_wready}, 0);
    @(posedge clk); #1;
    s_axi_awaddr = 5'h14; s_axi_awvalid = 1;
    @(posedge clk); #1;
    s_axi_awvalid = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("b_held", {31'b0, s_axi_bvalid}, 1);
      @(posedge clk); #1;
    end
    check("b_resp", {30'b0, s_axi_bresp}, 0);
    s_axi_bready = 1;
    @(posedge clk); #1;
    s_axi_bready = 0;
    check("b_done", {31'b0, s_axi_bvalid}, 0);
    model_write(5'h14, 32'd3, 4'hF);
    retire(32'h0, 32'h4, 32'h1, 0, 0);
    retire(32'h4, 32'h8, 32'h2, 0, 0);
    retire(32'h8, 32'hC, 32'h3, 0, 0);
    check("irq_same_cycle", {31'b0, trace_irq}, 0);
    @(posedge clk); #1;
    check("irq_next_cycle", {31'b0, trace_irq}, 1);

    // CLR coinciding with captures
    do_reset();
    reg_write(5'h00, 32'h1, 4'hF);
    for (int i = 0; i < 6; i++) retire(32'(i * 4), 32'(i * 4 + 4), 32'h7, 0, 0);
    check_status("pre_clr");
    pc = 32'h40; pc_next = 32'h44; instruction = 32'h9; i_cache_stall = 0;
    axi_write(5'h00, 32'h8, 4'hF, rr);
    i_cache_stall = 1;
    model_write(5'h00, 32'h8, 4'hF);
    check_status("clr");
    axi_read(5'h00, rd, rr);
    check("clr_reads_zero", rd, 32'd0);

    // Reset during R_RESP
    s_axi_araddr = 5'h04; s_axi_arvalid = 1;
    @(posedge clk); #1;
    s_axi_arvalid = 0;
    check("rvalid_pre_rst", {31'b0, s_axi_rvalid}, 1);
    rst = 1'b1;
    #1;
    check("rvalid_async_rst", {31'b0, s_axi_rvalid}, 0);
    do_reset();
    check("rvalid_post_rst", {31'b0, s_axi_rvalid}, 0);

    // Randomized rounds against the queue model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      reg_write(5'h14, (r == 0) ? 32'd0 : 32'($urandom_range(1, DEPTH)), 4'hF);
      reg_write(5'h00, 32'h1 | (32'($urandom_range(0, 3)) << 1), 4'hF);
      cur_pc = 32'h1000;
      for (int i = 0; i < 40; i++) begin
        if (i == 10) cur_pc = 32'hFFFF_FFFC;
        if (i == 10 || $urandom_range(0, 2) != 0) nxt_pc = cur_pc + 32'd4;
        else nxt_pc = $urandom() & 32'hFFFF_FFFC;
        retire(cur_pc, nxt_pc, $urandom(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        cur_pc = nxt_pc;
        idle_irq_check("rand");
        if ($urandom_range(0, 5) == 0) check_head("rand_mid");
      end
      check_status("rand_end");
      while (q.size() > 0) check_head("rand_drain");
      check_head("rand_empty");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
